mem_arbiter: RTL and testbench

- Shares the single memory port between the core's instruction-fetch requester (I) and load/store requester (D).
- One transaction is outstanding at a time.
- When both sides request, D has priority. A streak limit stops D from starving I.
- A wait-state timeout aborts a transaction that never completes, so a missing memory acknowledge cannot hang the core's FETCH/EXECUTE sequencing.

---
 rtl/mem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates one shared memory port between instruction-fetch (I) and load/store (D)
// requesters: D priority with a streak limit, one outstanding transaction, wait-state timeout.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STREAK_MAX = 3,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic [DATA_W-1:0]     i_rdata,
  output logic                  i_done,
  output logic                  i_err,
  input  logic                  d_req,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_wmask,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_done,
  output logic                  d_err,
  output logic                  m_req,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wmask,
  input  logic                  m_ack,
  input  logic [DATA_W-1:0]     m_rdata,
  output logic                  busy,
  output logic                  owner_d
);

  localparam int         MASK_W     = DATA_W / 8;
  localparam logic [3:0] STREAK_LIM = 4'(STREAK_MAX);
  localparam logic [7:0] WAIT_LIM   = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, GRANT, RESP} state_t;

  state_t              state_q, state_d;
  logic [3:0]          streak_q, streak_d;
  logic [7:0]          wait_q, wait_d;
  logic                m_req_q, m_req_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic [MASK_W-1:0]   m_wmask_q, m_wmask_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic                i_done_q, i_done_d;
  logic                i_err_q, i_err_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                d_done_q, d_done_d;
  logic                d_err_q, d_err_d;
  logic                busy_q, busy_d;
  logic                owner_d_q, owner_d_d;

  always_comb begin
    state_d   = state_q;
    streak_d  = streak_q;
    wait_d    = wait_q;
    m_req_d   = m_req_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_wmask_d = m_wmask_q;
    i_rdata_d = i_rdata_q;
    i_done_d  = i_done_q;
    i_err_d   = i_err_q;
    d_rdata_d = d_rdata_q;
    d_done_d  = d_done_q;
    d_err_d   = d_err_q;
    owner_d_d = owner_d_q;

    case (state_q)
      IDLE: begin
        if (d_req && !(i_req && streak_q == STREAK_LIM)) begin
          state_d   = GRANT;
          m_req_d   = 1'b1;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          m_wmask_d = d_wmask;
          owner_d_d = 1'b1;
          // D only beats a waiting I below the limit, so +1 never passes STREAK_MAX
          streak_d  = i_req ? streak_q + 4'd1 : '0;
        end else if (i_req) begin
          state_d   = GRANT;
          m_req_d   = 1'b1;
          m_addr_d  = i_addr;
          m_wdata_d = '0;
          m_wmask_d = '0;
          owner_d_d = 1'b0;
          streak_d  = '0;
        end
      end
      GRANT: begin
        if (m_ack) begin
          state_d = RESP;
          m_req_d = 1'b0;
          wait_d  = '0;
          if (owner_d_q) begin
            d_rdata_d = m_rdata;
            d_done_d  = 1'b1;
            d_err_d   = 1'b0;
          end else begin
            i_rdata_d = m_rdata;
            i_done_d  = 1'b1;
            i_err_d   = 1'b0;
          end
        end else if (wait_q + 8'd1 == WAIT_LIM) begin
          state_d = RESP;
          m_req_d = 1'b0;
          wait_d  = '0;
          if (owner_d_q) begin
            d_rdata_d = '0;
            d_done_d  = 1'b1;
            d_err_d   = 1'b1;
          end else begin
            i_rdata_d = '0;
            i_done_d  = 1'b1;
            i_err_d   = 1'b1;
          end
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      RESP: begin
        state_d  = IDLE;
        i_done_d = 1'b0;
        i_err_d  = 1'b0;
        d_done_d = 1'b0;
        d_err_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      streak_q  <= '0;
      wait_q    <= '0;
      m_req_q   <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_wmask_q <= '0;
      i_rdata_q <= '0;
      i_done_q  <= 1'b0;
      i_err_q   <= 1'b0;
      d_rdata_q <= '0;
      d_done_q  <= 1'b0;
      d_err_q   <= 1'b0;
      busy_q    <= 1'b0;
      owner_d_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      streak_q  <= streak_d;
      wait_q    <= wait_d;
      m_req_q   <= m_req_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_wmask_q <= m_wmask_d;
      i_rdata_q <= i_rdata_d;
      i_done_q  <= i_done_d;
      i_err_q   <= i_err_d;
      d_rdata_q <= d_rdata_d;
      d_done_q  <= d_done_d;
      d_err_q   <= d_err_d;
      busy_q    <= busy_d;
      owner_d_q <= owner_d_d;
    end
  end

  assign i_rdata = i_rdata_q;
  assign i_done  = i_done_q;
  assign i_err   = i_err_q;
  assign d_rdata = d_rdata_q;
  assign d_done  = d_done_q;
  assign d_err   = d_err_q;
  assign m_req   = m_req_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_wmask = m_wmask_q;
  assign busy    = busy_q;
  assign owner_d = owner_d_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table for the D/I streak pattern, directed corner sequences,
// then random requesters and memory checked against a transaction-level arbitration model.
module tb_mem_arbiter;

  localparam int STREAK = 3;
  localparam int TMO    = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, m_ack;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [3:0]  d_wmask;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic [3:0]  m_wmask;
  logic        i_done, i_err, d_done, d_err, m_req, busy, owner_d;

  // second instance with a longer timeout, used for the long-wait write
  logic        l_i_req, l_d_req, l_m_ack;
  logic [31:0] l_i_addr, l_d_addr, l_d_wdata, l_m_rdata;
  logic [3:0]  l_d_wmask;
  logic [31:0] l_i_rdata, l_d_rdata, l_m_addr, l_m_wdata;
  logic [3:0]  l_m_wmask;
  logic        l_i_done, l_i_err, l_d_done, l_d_err, l_m_req, l_busy, l_owner_d;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STREAK_MAX(STREAK), .TIMEOUT(TMO)) u_dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_err(i_err),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
    .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata), .m_wmask(m_wmask),
    .m_ack(m_ack), .m_rdata(m_rdata), .busy(busy), .owner_d(owner_d)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STREAK_MAX(STREAK), .TIMEOUT(8)) u_dut_long (
    .clk(clk), .reset(reset),
    .i_req(l_i_req), .i_addr(l_i_addr), .i_rdata(l_i_rdata), .i_done(l_i_done), .i_err(l_i_err),
    .d_req(l_d_req), .d_addr(l_d_addr), .d_wdata(l_d_wdata), .d_wmask(l_d_wmask),
    .d_rdata(l_d_rdata), .d_done(l_d_done), .d_err(l_d_err),
    .m_req(l_m_req), .m_addr(l_m_addr), .m_wdata(l_m_wdata), .m_wmask(l_m_wmask),
    .m_ack(l_m_ack), .m_rdata(l_m_rdata), .busy(l_busy), .owner_d(l_owner_d)
  );

  typedef struct {
    logic        i_req, d_req, m_ack;
    logic [31:0] m_rdata;
    logic        e_m_req, e_busy, e_owner_d, e_i_done, e_d_done;
    logic [31:0] e_addr;
  } vec_t;

  vec_t tbl [24];

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // One complete transaction on the main instance; returns at the IDLE-cycle sample after done.
  task automatic xact(input string nm, input bit exp_d, input int ack_at, input logic [31:0] ack_data,
                      input int max_wait, input logic [31:0] e_addr, input logic [31:0] e_wdata,
                      input logic [3:0] e_wmask);
    int k;
    bit acked;
    k = 1;
    step();
    while (!m_req && k < max_wait) begin
      step();
      k++;
    end
    check({nm, "_grant"}, {m_req, busy, owner_d}, {1'b1, 1'b1, exp_d});
    check({nm, "_fields"}, {m_addr, m_wdata, m_wmask}, {e_addr, e_wdata, e_wmask});
    acked = 1'b0;
    for (int c = 1; c <= TMO; c++) begin
      if (c > 1)
        check({nm, "_hold"}, {m_req, m_addr, m_wdata, m_wmask}, {1'b1, e_addr, e_wdata, e_wmask});
      if (c == ack_at) begin
        m_ack   = 1'b1;
        m_rdata = ack_data;
        acked   = 1'b1;
      end
      step();
      m_ack = 1'b0;
      if (acked) break;
    end
    check({nm, "_resp"}, {m_req, busy, i_done, d_done}, {1'b0, 1'b1, !exp_d, exp_d});
    if (exp_d) check({nm, "_data"}, {d_err, d_rdata}, {!acked, acked ? ack_data : 32'h0});
    else       check({nm, "_data"}, {i_err, i_rdata}, {!acked, acked ? ack_data : 32'h0});
    step();
    check({nm, "_clear"}, {busy, i_done, d_done, i_err, d_err}, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // random-phase model state
  int          ph, t_cyc, t_lat, streak_m, done_i, done_d;
  bit          t_d, t_ok, prev_want;
  logic [31:0] e_addr, e_wdata, t_data;
  logic [3:0]  e_wmask;
  logic [7:0]  own_order;

  initial begin
    reset = 1'b1;
    {i_req, d_req, m_ack} = '0;
    {i_addr, d_addr, d_wdata, m_rdata} = '0;
    d_wmask = '0;
    {l_i_req, l_d_req, l_m_ack} = '0;
    {l_i_addr, l_d_addr, l_d_wdata, l_m_rdata} = '0;
    l_d_wmask = '0;

    // ---------------- reset state ----------------
    step(); step(); step();
    check("reset_data", {i_rdata, d_rdata, m_addr, m_wdata}, '0);
    check("reset_ctl", {i_done, i_err, d_done, d_err, m_req, m_wmask, busy, owner_d}, '0);
    reset = 1'b0;
    step();
    check("post_reset_idle", {m_req, busy, owner_d, i_done, d_done}, '0);

    // ---------------- streak table: both held, memory always acking ----------------
    own_order = 8'b0111_0111;  // group g granted to D when bit g is set: D,D,D,I,D,D,D,I
    for (int g = 0; g < 8; g++) begin
      for (int p = 0; p < 3; p++) begin
        tbl[3*g+p].i_req     = 1'b1;
        tbl[3*g+p].d_req     = 1'b1;
        tbl[3*g+p].m_ack     = 1'b1;
        tbl[3*g+p].m_rdata   = 32'hA000_0000 | 32'(3*g+p);
        tbl[3*g+p].e_m_req   = (p == 0);
        tbl[3*g+p].e_busy    = (p != 2);
        tbl[3*g+p].e_owner_d = own_order[g];
        tbl[3*g+p].e_i_done  = (p == 1) && !own_order[g];
        tbl[3*g+p].e_d_done  = (p == 1) && own_order[g];
        tbl[3*g+p].e_addr    = own_order[g] ? 32'h40 : 32'h10;
      end
    end
    i_addr = 32'h10; d_addr = 32'h40; d_wdata = 32'h55AA_55AA; d_wmask = 4'hF;
    for (int r = 0; r < 24; r++) begin
      i_req = tbl[r].i_req; d_req = tbl[r].d_req;
      m_ack = tbl[r].m_ack; m_rdata = tbl[r].m_rdata;
      step();
      check("tbl_ctl", {m_req, busy, owner_d, i_done, d_done},
            {tbl[r].e_m_req, tbl[r].e_busy, tbl[r].e_owner_d, tbl[r].e_i_done, tbl[r].e_d_done});
      check("tbl_addr", m_addr, tbl[r].e_addr);
      if (tbl[r].e_d_done) check("tbl_d_rdata", {d_err, d_rdata}, {1'b0, tbl[r].m_rdata});
      if (tbl[r].e_i_done) check("tbl_i_rdata", {i_err, i_rdata}, {1'b0, tbl[r].m_rdata});
    end
    i_req = 1'b0; d_req = 1'b0; m_ack = 1'b0;
    step();

    // ---------------- I read only, ack in second m_req cycle ----------------
    i_req = 1'b1; i_addr = 32'h10;
    xact("iread", 1'b0, 2, 32'h0010_0093, 1, 32'h10, 32'h0, 4'h0);
    i_req = 1'b0;

    // ---------------- D write, 5 wait cycles, wdata changed mid-wait (long instance) ----------------
    l_d_req = 1'b1; l_d_addr = 32'h40; l_d_wdata = 32'hDEAD_BEEF; l_d_wmask = 4'b0011;
    step();
    check("dw_grant", {l_m_req, l_busy, l_owner_d}, 3'b111);
    for (int c = 1; c <= 6; c++) begin
      check("dw_fields", {l_m_req, l_m_addr, l_m_wdata, l_m_wmask}, {1'b1, 32'h40, 32'hDEAD_BEEF, 4'b0011});
      check("dw_no_done", {l_d_done, l_i_done}, 2'b00);
      if (c == 3) l_d_wdata = 32'h1234_5678;
      if (c == 6) begin l_m_ack = 1'b1; l_m_rdata = 32'hCAFE_0001; end
      step();
    end
    l_m_ack = 1'b0;
    check("dw_done", {l_m_req, l_d_done, l_d_err, l_i_done, l_d_rdata}, {4'b0100, 32'hCAFE_0001});
    l_d_req = 1'b0;
    step();
    check("dw_clear", {l_d_done, l_d_err, l_busy}, 3'b000);

    // ---------------- timeout with I pending, then I served ----------------
    i_req = 1'b1; i_addr = 32'h20;
    d_req = 1'b1; d_addr = 32'h44; d_wdata = 32'h0BAD_F00D; d_wmask = 4'h0;
    xact("tmo", 1'b1, 0, 32'h0, 1, 32'h44, 32'h0BAD_F00D, 4'h0);
    d_req = 1'b0;
    xact("tmo_then_i", 1'b0, 1, 32'h1357_9BDF, 1, 32'h20, 32'h0, 4'h0);
    i_req = 1'b0;

    // ---------------- ack on the timeout cycle ----------------
    d_req = 1'b1; d_addr = 32'h48; d_wdata = 32'h0; d_wmask = 4'h0;
    xact("tmo_ack", 1'b1, TMO, 32'hACED_0004, 1, 32'h48, 32'h0, 4'h0);
    d_req = 1'b0;

    // ---------------- async reset mid-GRANT with streak at its limit ----------------
    i_req = 1'b1; i_addr = 32'h20;
    d_req = 1'b1; d_addr = 32'h80; d_wdata = 32'h1111_2222; d_wmask = 4'hF;
    xact("rst_pre1", 1'b1, 1, 32'h0000_0001, 1, 32'h80, 32'h1111_2222, 4'hF);
    xact("rst_pre2", 1'b1, 1, 32'h0000_0002, 1, 32'h80, 32'h1111_2222, 4'hF);
    step();
    check("rst_third_grant", {m_req, owner_d}, 2'b11);
    step();
    check("rst_still_waiting", {m_req, owner_d, d_done}, 3'b110);
    #2 reset = 1'b1;
    #1 check("rst_async", {m_req, busy, owner_d, i_done, d_done}, '0);
    step();
    check("rst_held", {m_req, busy, owner_d, i_done, d_done}, '0);
    reset = 1'b0;
    xact("rst_post_d", 1'b1, 1, 32'h0000_0003, 1, 32'h80, 32'h1111_2222, 4'hF);
    d_req = 1'b0;
    xact("rst_post_i", 1'b0, 1, 32'h0000_0004, 1, 32'h20, 32'h0, 4'h0);
    i_req = 1'b0;

    // ---------------- random requesters and memory vs. transaction model ----------------
    ph = 0; prev_want = 1'b0; streak_m = 0; done_i = 0; done_d = 0;
    t_d = 1'b0; t_cyc = 0; t_lat = 1; t_data = '0;
    e_addr = '0; e_wdata = '0; e_wmask = '0;
    for (int n = 0; n < 3000; n++) begin
      step();
      m_ack   = 1'($urandom_range(0, 1));
      m_rdata = $urandom;
      if (ph == 0 && prev_want) begin
        t_d = d_req && !(i_req && streak_m == STREAK);
        if (t_d && i_req) streak_m = (streak_m < STREAK) ? streak_m + 1 : STREAK;
        else              streak_m = 0;
        e_addr  = t_d ? d_addr  : i_addr;
        e_wdata = t_d ? d_wdata : 32'h0;
        e_wmask = t_d ? d_wmask : 4'h0;
        check("rnd_grant", {m_req, busy, owner_d, i_done, d_done}, {1'b1, 1'b1, t_d, 1'b0, 1'b0});
        check("rnd_fields", {m_addr, m_wdata, m_wmask}, {e_addr, e_wdata, e_wmask});
        ph = 1; t_cyc = 1;
        t_lat  = $urandom_range(1, 6);
        t_data = $urandom;
      end else if (ph == 1) begin
        check("rnd_hold", {m_req, busy, i_done, d_done, m_addr, m_wdata, m_wmask},
              {4'b1100, e_addr, e_wdata, e_wmask});
        t_cyc++;
      end else if (ph == 2) begin
        t_ok = (t_lat <= TMO);
        check("rnd_done", {m_req, busy, i_done, d_done}, {1'b0, 1'b1, !t_d, t_d});
        if (t_d) check("rnd_d_resp", {d_err, d_rdata}, {!t_ok, t_ok ? t_data : 32'h0});
        else     check("rnd_i_resp", {i_err, i_rdata}, {!t_ok, t_ok ? t_data : 32'h0});
        if (t_d) begin
          done_d++;
          if ($urandom_range(0, 1) == 1) begin
            d_addr = $urandom; d_wdata = $urandom; d_wmask = 4'($urandom);
          end else d_req = 1'b0;
        end else begin
          done_i++;
          if ($urandom_range(0, 1) == 1) i_addr = $urandom;
          else i_req = 1'b0;
        end
        ph = 3;
      end else begin
        check("rnd_idle", {m_req, busy, i_done, d_done}, '0);
        ph = 0;
      end
      if (ph == 1) begin
        if (t_cyc == t_lat) begin
          m_ack = 1'b1; m_rdata = t_data; ph = 2;
        end else begin
          m_ack = 1'b0;
          if (t_cyc == TMO) ph = 2;
        end
        d_wdata = $urandom;
      end
      if (!i_req && $urandom_range(0, 2) == 0) begin
        i_req = 1'b1; i_addr = $urandom;
      end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_addr = $urandom; d_wdata = $urandom; d_wmask = 4'($urandom);
      end
      prev_want = i_req || d_req;
    end
    check("rnd_progress", {done_i >= 30, done_d >= 30}, 2'b11);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
